// File: rtl/load_buffer_pkg.sv
// Shared load-buffer types: entry record, controller states, sizing.
// Imported by the load buffer and by anything that talks to it.
`ifndef LOAD_BUFFER_LENGTH
`define LOAD_BUFFER_LENGTH 8
`endif

package load_buffer_pkg;

  localparam int LOAD_BUFFER_LENGTH = `LOAD_BUFFER_LENGTH;
  localparam int ROB_LENGTH = 16;
  localparam int ROB_ADDR_W = $clog2(ROB_LENGTH);

  // addr lives in a parallel array so DATA_W can stay a module parameter
  typedef struct packed {
    logic                  valid;
    logic                  addr_ready;
    logic [ROB_ADDR_W-1:0] rob_addr;
  } load_entry_t;

  typedef enum logic [2:0] {
    LC_IDLE,
    LC_WAIT_ADDR,
    LC_BLOCKED,
    LC_REQ,
    LC_WAIT_RESP,
    LC_WB
  } lc_state_e;

endpackage

// File: rtl/load_buffer.sv
// In-order load buffer: allocates at dispatch, waits for address and
// older stores, issues one memory read at a time, writes back to ROB.
module load_buffer
  import load_buffer_pkg::*;
#(
  parameter int LENGTH = LOAD_BUFFER_LENGTH,
  parameter int DATA_W = 16,
  localparam int IDX_W = $clog2(LENGTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ROB_ADDR_W-1:0] push_rob_addr,
  output logic                  full,
  output logic [IDX_W-1:0]      push_idx,
  input  logic                  addr_valid,
  input  logic [IDX_W-1:0]      addr_idx,
  input  logic [DATA_W-1:0]     addr,
  output logic [ROB_ADDR_W-1:0] query_rob_addr,
  input  logic                  older_store_block,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_W-1:0]     mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data,
  output logic                  wb_valid,
  output logic [ROB_ADDR_W-1:0] wb_rob_addr,
  output logic [DATA_W-1:0]     wb_data,
  input  logic                  flush
);

  lc_state_e   state_q, state_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic        drop_q, drop_d;
  logic [DATA_W-1:0] data_q, data_d;
  load_entry_t ent_q [LENGTH];
  load_entry_t ent_d [LENGTH];
  logic [DATA_W-1:0] addr_q [LENGTH];
  logic [DATA_W-1:0] addr_d [LENGTH];

  load_entry_t head_ent;
  logic        push_ok;
  logic        wb_fire;
  logic        head_addr_hit;

  assign head_ent = ent_q[head_q];
  assign full     = (count_q == CNT_W'(LENGTH));
  assign push_idx = tail_q;
  assign push_ok  = push && !full;
  assign wb_fire  = (state_q == LC_WB);

  // address arriving for the head this cycle skips a WAIT_ADDR cycle
  assign head_addr_hit = addr_valid && head_ent.valid
                      && (addr_idx == head_q);

  assign query_rob_addr = head_ent.valid ? head_ent.rob_addr : '0;
  assign mem_req_valid  = (state_q == LC_REQ);
  assign mem_req_addr   = addr_q[head_q];
  assign wb_valid       = wb_fire;
  assign wb_rob_addr    = head_ent.rob_addr;
  assign wb_data        = data_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;
    data_d  = data_q;
    ent_d   = ent_q;
    addr_d  = addr_q;

    unique case (state_q)
      LC_IDLE: begin
        if (!drop_q && count_q != '0) state_d = LC_WAIT_ADDR;
      end
      LC_WAIT_ADDR: begin
        if (head_ent.addr_ready || head_addr_hit) state_d = LC_BLOCKED;
      end
      LC_BLOCKED: begin
        if (!older_store_block) state_d = LC_REQ;
      end
      LC_REQ: begin
        if (mem_req_ready) state_d = LC_WAIT_RESP;
      end
      LC_WAIT_RESP: begin
        if (mem_resp_valid) begin
          state_d = LC_WB;
          data_d  = mem_resp_data;
        end
      end
      LC_WB: begin
        state_d = LC_IDLE;
      end
      default: state_d = LC_IDLE;
    endcase

    if (drop_q && mem_resp_valid) drop_d = 1'b0;

    if (addr_valid && ent_q[addr_idx].valid) begin
      ent_d[addr_idx].addr_ready = 1'b1;
      addr_d[addr_idx] = addr;
    end

    if (wb_fire) begin
      ent_d[head_q] = '0;
      head_d = head_q + IDX_W'(1);
    end

    if (push_ok) begin
      ent_d[tail_q].valid      = 1'b1;
      ent_d[tail_q].addr_ready = 1'b0;
      ent_d[tail_q].rob_addr   = push_rob_addr;
      tail_d = tail_q + IDX_W'(1);
    end

    count_d = count_q + CNT_W'(push_ok) - CNT_W'(wb_fire);

    if (flush) begin
      for (int i = 0; i < LENGTH; i++) ent_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = LC_IDLE;
      // a read still in flight must be swallowed when it returns
      drop_d  = (drop_q
              || (state_q == LC_WAIT_RESP)
              || (state_q == LC_REQ && mem_req_ready))
              && !mem_resp_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LC_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < LENGTH; i++) ent_q[i] <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      ent_q   <= ent_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    addr_q <= addr_d;
  end

endmodule

// File: doc/load_buffer.md
LOAD_BUFFER -- requirements
Module: load_buffer

Interface
REQ-001 Parameter LENGTH, default `LOAD_BUFFER_LENGTH (8), entry count; power of two, at least 2.
REQ-002 Parameter DATA_W, default 16, address and data width.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 push  in  1  allocate one load at dispatch; push_rob_addr  in  ROB_ADDR_W  owning ROB entry.
REQ-006 full  out  1  count==LENGTH; push_idx  out  clog2(LENGTH)  slot allocated by push (equals tail).
REQ-007 addr_valid  in  1, addr_idx  in  clog2(LENGTH), addr  in  DATA_W: computed address delivered to slot addr_idx.
REQ-008 query_rob_addr  out  ROB_ADDR_W  head entry's ROB address, sent to store buffer.
REQ-009 older_store_block  in  1  store buffer holds an uncommitted store older than query_rob_addr.
REQ-010 mem_req_valid  out  1, mem_req_ready  in  1, mem_req_addr  out  DATA_W: read-request handshake.
REQ-011 mem_resp_valid  in  1, mem_resp_data  in  DATA_W: read response, one per accepted request, any latency ≥1 cycle.
REQ-012 wb_valid  out  1, wb_rob_addr  out  ROB_ADDR_W, wb_data  out  DATA_W: one-cycle completion pulse to ROB.
REQ-013 flush  in  1  discard every entry (misprediction recovery).

Function
REQ-014 Circular buffer of load_entry records {valid, addr_ready, addr, rob_addr}; head, tail, and count registers; indices wrap modulo LENGTH.
REQ-015 push while full is ignored; push while not full writes the entry at tail with valid=1 and addr_ready=0, and increments tail and count.
REQ-016 addr_valid sets addr_ready and addr in slot addr_idx; addr_valid to an invalid slot is ignored.
REQ-017 Loads are serviced strictly in order from head by a controller with states IDLE, WAIT_ADDR, BLOCKED, REQ, WAIT_RESP, WB.
REQ-018 IDLE→WAIT_ADDR when count>0.
REQ-019 WAIT_ADDR→BLOCKED when the head entry has addr_ready.
REQ-020 BLOCKED→REQ in the first cycle older_store_block=0.
REQ-021 In REQ, mem_req_valid=1 and mem_req_addr=head addr; the state moves to WAIT_RESP on the cycle mem_req_ready=1.
REQ-022 WAIT_RESP→WB on mem_resp_valid; mem_resp_data is latched.
REQ-023 WB asserts wb_valid for exactly one cycle with the head rob_addr and the latched data, then clears the head entry, advances head, decrements count, and returns to IDLE.
REQ-024 Minimum latency from addr_valid on an unblocked head to wb_valid is 4 cycles with zero-wait memory.
REQ-025 Push and WB in the same cycle: count is unchanged, while head and tail both advance.
REQ-026 A push that would land in the slot being freed by WB in the same cycle is permitted only when not full at cycle start.
REQ-027 On flush, all valid bits clear and head, tail, and count go to 0; flush has priority over push, addr_valid, and WB in the same cycle.
REQ-028 Flush in WAIT_RESP sets drop_resp; the next mem_resp_valid is discarded and then clears drop_resp, and no wb_valid is produced for it.
REQ-029 While drop_resp=1, the controller holds in IDLE and issues no new request.
REQ-030 Flush in REQ withdraws mem_req_valid the following cycle; if the request was accepted in the flush cycle, drop_resp is set.
REQ-031 No other output is registered beyond the described state.

Reset
REQ-032 Reset clears the following: head, tail, count, all valid bits, drop_resp, and state=IDLE.
REQ-033 Outputs during and after reset: full=0, mem_req_valid=0, wb_valid=0, query_rob_addr=0.
REQ-034 Reset mid-transaction abandons any outstanding response without setting drop_resp; the memory side is reset concurrently.

Structure
REQ-035 load_entry typedef, the LOAD_BUFFER_LENGTH constant, and the load-controller state enum reside in the shared nand_cpu package/header.
REQ-036 ROB_ADDR_W is derived as clog2(ROB_LENGTH) in the shared header.
REQ-037 Single module; no sub-module is required.

Verification
REQ-038 Push rob=3, addr_valid idx0 addr=0x0040, older_store_block=0, zero-wait memory returning 0xBEEF -> wb_valid exactly 4 cycles after addr_valid, wb_rob_addr=3, wb_data=0xBEEF.
REQ-039 Push 8 loads -> full=1; 9th push ignored; after 8 completions the wb_rob_addr sequence matches push order and count=0.
REQ-040 Addresses delivered out of order (idx2, idx1, idx0) -> writebacks still ordered idx0, idx1, idx2.
REQ-041 older_store_block held high 5 cycles with head ready -> mem_req_valid stays 0 for those 5 cycles and rises the cycle after the block drops.
REQ-042 Flush in WAIT_RESP, then response 0x1234 arrives 3 cycles later -> no wb_valid; the next pushed load completes normally with its own data.
REQ-043 Head/tail wrap: 20 push/complete pairs with simultaneous push and WB -> count constant, no lost or duplicated wb_rob_addr.
